// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
//   Single-port SRAM front end. After reset the controller optionally
//   zero-fills the whole array, then serves a valid/ready request stream.
//   Writes go straight to the SRAM. Reads return data through a 2-entry
//   response FIFO, in request order. SRAM read data (sram_q) is sampled only
//   in the cycle after a read enable, because it is garbage at any other time.
//
// Parameters
//   BITS     SRAM data width
//   DEPTH    SRAM word count
//   AW       address width
//   INIT_EN  1 = zero-fill the SRAM after reset, 0 = go straight to RUN
//
// Ports
//   CLK, RSTB                  clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake; "fire" = both high at the edge
//   req_write                  1 = write, 0 = read
//   req_addr, req_wdata        request address and write data
//   resp_valid/resp_ready      read-response handshake
//   resp_rdata                 read data (head of the response FIFO)
//   sram_ceb, sram_web         SRAM chip enable and write enable, active-low
//   sram_a, sram_d, sram_q     SRAM address, write data and read data
//   init_done                  high once the controller is in RUN
// -----------------------------------------------------------------------------
module sram_port_ctrl #(
  parameter int BITS    = 32,
  parameter int DEPTH   = 128,
  parameter int AW      = 7,
  parameter int INIT_EN = 1
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [BITS-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [BITS-1:0] resp_rdata,
  output logic            sram_ceb,
  output logic            sram_web,
  output logic [AW-1:0]   sram_a,
  output logic [BITS-1:0] sram_d,
  input  logic [BITS-1:0] sram_q,
  output logic            init_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]      r_state;
  logic [AW-1:0]   r_init_cnt;
  logic            r_inflight;   // sram_q carries read data this cycle
  logic [BITS-1:0] r_fifo [0:1];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;

  logic            w_run;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_used;
  logic            w_fire;
  logic            w_read_fire;

  assign w_run  = (r_state == ST_RUN);
  assign w_push = r_inflight;
  assign w_pop  = resp_valid && resp_ready;

  // Slots claimed by buffered and in-flight reads. A pop in this same cycle
  // frees its slot before the new read's data can arrive, so it is credited
  // back here; that is what keeps back-to-back reads flowing at full rate.
  // When resp_ready is low this reduces to fifo_count + inflight < 2.
  assign w_used = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

  assign req_ready   = w_run && (req_write || (w_used < 2'd2));
  assign w_fire      = req_valid && req_ready;
  assign w_read_fire = w_fire && !req_write;

  assign resp_valid = (r_count != 2'd0);
  assign resp_rdata = r_fifo[r_rptr];
  assign init_done  = w_run;

  // SRAM pins: zero-fill pattern in INIT, pass-through of the request in RUN.
  // NOTE: every output gets a default first so no path through the case can
  // leave a value held, which would infer a latch.
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    case (r_state)
      ST_INIT: begin
        sram_ceb = 1'b0;
        sram_web = 1'b0;
        sram_a   = r_init_cnt;
      end
      ST_RUN: begin
        sram_ceb = !w_fire;
        sram_web = !req_write;
        sram_a   = req_addr;
        sram_d   = req_wdata;
      end
      default: ;
    endcase
  end

  // Control state, init counter, read tracking and FIFO bookkeeping.
  // NOTE: state registers use non-blocking assignments so every block sees
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state    <= ST_IDLE;
      r_init_cnt <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_init_cnt <= '0;
          r_state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
        end
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == LAST_ADDR) r_state <= ST_RUN;
        end
        default: ;
      endcase

      r_inflight <= w_read_fire;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // NOTE: FIFO storage is not reset; r_count gates visibility, so stale
  // contents can never reach resp_valid and the reset fan-out is avoided.
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= sram_q;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_port_ctrl
//   Directed bench for sram_port_ctrl (default parameters). A behavioural
//   SRAM returns stored data the cycle after a read enable and random data in
//   every other cycle, and is refilled with a non-zero pattern during reset so
//   that the zero-fill is observable. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_sram_port_ctrl;

  localparam int BITS  = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic            CLK = 1'b0;
  logic            RSTB;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [BITS-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [BITS-1:0] resp_rdata;
  logic            sram_ceb;
  logic            sram_web;
  logic [AW-1:0]   sram_a;
  logic [BITS-1:0] sram_d;
  logic [BITS-1:0] sram_q;
  logic            init_done;

  int n_checks = 0;
  int n_errors = 0;

  // Outputs captured at the falling edge of the last cycle driven by cyc().
  logic            s_ready;
  logic            s_rv;
  logic [BITS-1:0] s_rd;
  logic            s_ceb;
  logic            s_web;
  logic [AW-1:0]   s_a;
  logic [BITS-1:0] s_d;

  int done_cyc;
  int n_writes;
  int n_bad;

  always #5 CLK = ~CLK;

  sram_port_ctrl #(
    .BITS    (BITS),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .INIT_EN (1)
  ) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_ceb   (sram_ceb),
    .sram_web   (sram_web),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q),
    .init_done  (init_done)
  );

  // Behavioural SRAM: q is valid only the cycle after a read, random otherwise.
  logic [BITS-1:0] mem [0:DEPTH-1];
  always @(posedge CLK) begin
    if (!RSTB) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      sram_q <= $urandom;
    end else begin
      if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
      else                       sram_q <= $urandom;
      if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, capture outputs mid-cycle, end just after the edge.
  task automatic cyc(input logic v, input logic w, input logic [AW-1:0] a,
                     input logic [BITS-1:0] d, input logic rr);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = rr;
    @(negedge CLK);
    s_ready = req_ready;
    s_rv    = resp_valid;
    s_rd    = resp_rdata;
    s_ceb   = sram_ceb;
    s_web   = sram_web;
    s_a     = sram_a;
    s_d     = sram_d;
    @(posedge CLK);
    #1;
  endtask

  // Called just after reset release with req_valid=1/req_write=1 applied.
  // Cycle 1 is the cycle in which reset is released.
  task automatic run_init(output int done, output int nw, output int bad);
    int c;
    done = 0;
    nw   = 0;
    bad  = 0;
    c    = 1;
    while (c < 400) begin
      @(negedge CLK);
      if (init_done) begin
        done = c;
        break;
      end
      if (req_ready !== 1'b0) bad++;
      if (c == 1 && sram_ceb !== 1'b1) bad++;
      if (sram_ceb === 1'b0) begin
        if (sram_web !== 1'b0 || sram_a !== AW'(nw) || sram_d !== '0) bad++;
        nw++;
      end
      @(posedge CLK);
      #1;
      c++;
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTB       = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_init_done",  32'(init_done),  32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_ceb",        32'(sram_ceb),   32'd1);

    // Zero-fill: 128 writes to 0..127, RUN on cycle 130
    @(posedge CLK);
    #1;
    RSTB      = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    run_init(done_cyc, n_writes, n_bad);
    check("init_done_cycle", 32'(done_cyc), 32'd130);
    check("init_writes",     32'(n_writes), 32'd128);
    check("init_sequence",   32'(n_bad),    32'd0);

    // Reads after init return zero
    cyc(1'b1, 1'b0, 7'd0, 32'h0, 1'b1);
    check("rd0_ready", 32'(s_ready), 32'd1);
    check("rd0_ceb",   32'(s_ceb),   32'd0);
    check("rd0_web",   32'(s_web),   32'd1);
    cyc(1'b1, 1'b0, 7'd127, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("z0_valid",   32'(s_rv), 32'd1);
    check("z0_data",    s_rd,      32'h0);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("z127_valid", 32'(s_rv), 32'd1);
    check("z127_data",  s_rd,      32'h0);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("z_end_valid", 32'(s_rv), 32'd0);

    // Write then read the same address on the next cycle
    cyc(1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b1);
    check("wr5_ready", 32'(s_ready), 32'd1);
    check("wr5_ceb",   32'(s_ceb),   32'd0);
    check("wr5_web",   32'(s_web),   32'd0);
    check("wr5_addr",  32'(s_a),     32'd5);
    check("wr5_data",  s_d,          32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 7'd5, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("raw_early_valid", 32'(s_rv), 32'd0);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("raw_valid", 32'(s_rv), 32'd1);
    check("raw_data",  s_rd,       32'hDEAD_BEEF);

    // Back-to-back reads of 1..4 with resp_ready=1
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, AW'(i), 32'h1111_1111 * 32'(i), 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, AW'(i), 32'h0, 1'b1);
      check("b2b_ready", 32'(s_ready), 32'd1);
      if (i >= 3) begin
        check("b2b_valid", 32'(s_rv), 32'd1);
        check("b2b_data",  s_rd,      32'h1111_1111 * 32'(i - 2));
      end else begin
        check("b2b_early_valid", 32'(s_rv), 32'd0);
      end
    end
    for (int i = 3; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
      check("b2b_tail_valid", 32'(s_rv), 32'd1);
      check("b2b_tail_data",  s_rd,      32'h1111_1111 * 32'(i));
    end
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("b2b_end_valid", 32'(s_rv), 32'd0);

    // Back-pressure: only two reads accepted, writes still go through
    cyc(1'b1, 1'b0, 7'd1, 32'h0, 1'b0);
    check("bp_rd1_ready", 32'(s_ready), 32'd1);
    cyc(1'b1, 1'b0, 7'd2, 32'h0, 1'b0);
    check("bp_rd2_ready", 32'(s_ready), 32'd1);
    cyc(1'b1, 1'b0, 7'd3, 32'h0, 1'b0);
    check("bp_rd3_ready", 32'(s_ready), 32'd0);
    check("bp_rd3_ceb",   32'(s_ceb),   32'd1);
    check("bp_head_a",    s_rd,         32'h1111_1111);
    cyc(1'b1, 1'b0, 7'd3, 32'h0, 1'b0);
    check("bp_rd4_ready", 32'(s_ready), 32'd0);
    check("bp_head_b",    s_rd,         32'h1111_1111);
    cyc(1'b1, 1'b1, 7'd9, 32'hCAFE_0009, 1'b0);
    check("bp_wr_ready",  32'(s_ready), 32'd1);
    check("bp_wr_ceb",    32'(s_ceb),   32'd0);
    check("bp_head_c",    s_rd,         32'h1111_1111);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("drain1_valid", 32'(s_rv), 32'd1);
    check("drain1_data",  s_rd,      32'h1111_1111);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("drain2_valid", 32'(s_rv), 32'd1);
    check("drain2_data",  s_rd,      32'h2222_2222);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("drain_end_valid", 32'(s_rv), 32'd0);

    // Reset with one read in flight and one entry buffered
    cyc(1'b1, 1'b0, 7'd1, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 7'd2, 32'h0, 1'b0);
    req_valid = 1'b0;
    @(negedge CLK);
    check("mid_pre_valid", 32'(resp_valid), 32'd1);
    #1;
    RSTB = 1'b0;
    #1;
    check("mid_rst_valid",     32'(resp_valid), 32'd0);
    check("mid_rst_ready",     32'(req_ready),  32'd0);
    check("mid_rst_init_done", 32'(init_done),  32'd0);
    check("mid_rst_ceb",       32'(sram_ceb),   32'd1);
    repeat (3) @(posedge CLK);
    #1;
    RSTB       = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    resp_ready = 1'b1;
    run_init(done_cyc, n_writes, n_bad);
    check("reinit_done_cycle", 32'(done_cyc), 32'd130);
    check("reinit_writes",     32'(n_writes), 32'd128);
    check("reinit_sequence",   32'(n_bad),    32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
      check("no_stale_valid", 32'(s_rv), 32'd0);
    end
    cyc(1'b1, 1'b0, 7'd5, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("reinit_rd5_valid", 32'(s_rv), 32'd1);
    check("reinit_rd5_data",  s_rd,       32'h0);

    // Random sram_q between reads must never be captured
    cyc(1'b1, 1'b1, 7'd20, 32'h1234_5678, 1'b1);
    cyc(1'b1, 1'b1, 7'd21, 32'h9ABC_DEF0, 1'b1);
    cyc(1'b1, 1'b0, 7'd20, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 7'd21, 32'h0, 1'b1);
    check("rq_early_valid", 32'(s_rv), 32'd0);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("rq20_valid", 32'(s_rv), 32'd1);
    check("rq20_data",  s_rd,      32'h1234_5678);
    cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
    check("rq21_valid", 32'(s_rv), 32'd1);
    check("rq21_data",  s_rd,      32'h9ABC_DEF0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1);
      check("rq_quiet_valid", 32'(s_rv), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 32, SRAM data width.
REQ-002 SHALL have parameter DEPTH, default 128, SRAM word count.
REQ-003 SHALL have parameter AW, default 7, address width.
REQ-004 SHALL have parameter INIT_EN, default 1, zero-fill SRAM after reset when 1.
REQ-005 SHALL have CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have RSTB  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have req_valid  input  1  request present.
REQ-008 SHALL have req_ready  output  1  request accepted when both high at the clock edge ("fire").
REQ-009 SHALL have req_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have req_addr  input  AW  word address.
REQ-011 SHALL have req_wdata  input  BITS  write data.
REQ-012 SHALL have resp_valid  output  1  read data available.
REQ-013 SHALL have resp_ready  input  1  consumer takes response.
REQ-014 SHALL have resp_rdata  output  BITS  read data, in request order.
REQ-015 SHALL have sram_ceb  output  1  SRAM chip enable, active-low.
REQ-016 SHALL have sram_web  output  1  SRAM write enable, active-low (1 = read).
REQ-017 SHALL have sram_a  output  AW  SRAM address.
REQ-018 SHALL have sram_d  output  BITS  SRAM write data.
REQ-019 SHALL have sram_q  input  BITS  SRAM read data, valid only the cycle after a read enable; other cycles garbage.
REQ-020 SHALL have init_done  output  1  high once state is RUN.

Function
REQ-021 SHALL implement states IDLE, INIT, RUN; IDLE lasts one cycle after reset release, then INIT if INIT_EN=1 else RUN.
REQ-022 In INIT SHALL drive sram_ceb=0, sram_web=0, sram_a=init_cnt, sram_d=0; init_cnt increments each cycle from 0; at init_cnt=DEPTH-1 next state RUN.
REQ-023 In IDLE and INIT SHALL hold req_ready=0; in IDLE sram_ceb=1.
REQ-024 In RUN SHALL drive SRAM combinationally from the request: sram_ceb = !fire, sram_web = !req_write, sram_a = req_addr, sram_d = req_wdata; no fire -> sram_ceb=1.
REQ-025 In RUN SHALL set req_ready=1 for writes; for reads req_ready=1 only when fifo_count + inflight < 2.
REQ-026 Read fire SHALL set inflight=1 for exactly the next cycle, in which sram_q is pushed into a 2-entry response FIFO; sram_q SHALL be ignored in all other cycles.
REQ-027 Read latency SHALL be 2 cycles from fire edge to resp_valid with empty FIFO; sustained one read per cycle when resp_ready=1.
REQ-028 resp_valid SHALL equal fifo_count != 0; resp_rdata SHALL be the head entry, stable while resp_valid=1 and resp_ready=0.
REQ-029 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-030 Writes SHALL produce no response; a read after a write to the same address in the next cycle SHALL return the new data.
REQ-031 FIFO pointers SHALL wrap modulo 2; credit rule guarantees no overflow; pop on empty SHALL not occur.

Reset
REQ-032 RSTB low SHALL asynchronously force state=IDLE, init_cnt=0, inflight=0, fifo_count=0, pointers=0, resp_valid=0, req_ready=0, init_done=0, sram_ceb=1.
REQ-033 Reset asserted mid-INIT or mid-read SHALL discard in-flight data; after release, INIT restarts at address 0.

Verification
REQ-034 Reset release, INIT_EN=1, DEPTH=128: exactly 128 zero writes addr 0..127, init_done high on cycle 130, then reads of any address return 0.
REQ-035 Write addr 5 = 0xDEADBEEF, next cycle read addr 5 -> resp_valid 2 cycles later, resp_rdata = 0xDEADBEEF.
REQ-036 Reads addr 1,2,3,4 back-to-back with resp_ready=1 -> four responses on consecutive cycles, in order, req_ready never drops.
REQ-037 resp_ready=0, issue reads continuously -> exactly 2 reads accepted, req_ready=0 for reads, writes still accepted; raising resp_ready drains in order.
REQ-038 Assert RSTB low while one read in flight and FIFO holds one entry -> resp_valid=0 immediately, no stale response after INIT completes.
REQ-039 sram_q driven random every cycle -> responses match written data only; no garbage captured.
